tmr_vote_monitor: RTL and testbench

Registered, parametrised triple-modular-redundancy voter for W-bit buses. It votes bit-wise across three redundant channels and tracks per-channel consecutive disagreement. Any channel that disagrees for THRESH consecutive samples is masked out of future votes. It sits between replicated datapath copies and downstream logic, and is the sequential, multi-bit successor to the single-bit combinational majority gate.

---
 rtl/tmr_vote_monitor_if.sv | 34 +++
 rtl/tmr_vote_monitor.sv | 123 ++++++++++++
 tb/tb_tmr_vote_monitor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tmr_vote_monitor_if.sv
// tmr_vote_monitor_if
// Groups the sample inputs and the voted/status outputs of tmr_vote_monitor.
//   in_valid, a, b, c, clr_fault : sample and fault-clear request (producer side)
//   out_valid, y, disagree, split: voted result, one cycle after the sample
//   fault_mask, all_failed       : sticky per-channel mask and "all masked" flag
//   event_cnt                    : saturating count of disagreeing samples
// Modport slave is used by the voter, master by whoever drives the samples.
interface tmr_vote_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             clr_fault;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             disagree;
  logic             split;
  logic [2:0]       fault_mask;
  logic             all_failed;
  logic [CNT_W-1:0] event_cnt;

  modport master (
    output in_valid, a, b, c, clr_fault,
    input  out_valid, y, disagree, split, fault_mask, all_failed, event_cnt
  );

  modport slave (
    input  in_valid, a, b, c, clr_fault,
    output out_valid, y, disagree, split, fault_mask, all_failed, event_cnt
  );
endinterface

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor
// Registered bit-wise triple-modular-redundancy voter with per-channel
// consecutive-disagreement tracking. A channel that differs from the 3-way
// majority for THRESH consecutive valid samples is masked out of later votes.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset (priority over everything)
//   bus  : tmr_vote_monitor_if.slave (samples in, voted result and status out)
// The interface parameters WIDTH/CNT_W must match this module's parameters.
module tmr_vote_monitor #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  tmr_vote_monitor_if.slave   bus
);

  localparam int MW = $clog2(THRESH + 1);
  localparam logic [MW-1:0]    MCNT_ONE  = MW'(1'b1);
  localparam logic [MW-1:0]    MCNT_ZERO = MW'(1'b0);
  localparam logic [MW-1:0]    THRESH_V  = MW'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [2:0][WIDTH-1:0] ch;
  logic [WIDTH-1:0]      maj;
  logic                  d_ab, d_bc, d_ac;
  logic [WIDTH-1:0]      y_vote;
  logic                  split_vote;
  logic                  dis_vote;
  logic [2:0]            mism;
  logic [2:0][MW-1:0]    mcnt;
  logic [2:0][MW-1:0]    mcnt_nxt;
  logic [2:0]            mask_nxt;

  assign ch = {bus.c, bus.b, bus.a};

  // Vote, split and disagree for the current sample, selected by the current (old) mask
  always_comb begin
    maj  = (bus.a & bus.b) | (bus.b & bus.c) | (bus.a & bus.c);
    d_ab = |(bus.a ^ bus.b);
    d_bc = |(bus.b ^ bus.c);
    d_ac = |(bus.a ^ bus.c);
    // A pair only counts when neither member is masked
    dis_vote = (d_ab & ~bus.fault_mask[0] & ~bus.fault_mask[1]) |
               (d_bc & ~bus.fault_mask[1] & ~bus.fault_mask[2]) |
               (d_ac & ~bus.fault_mask[0] & ~bus.fault_mask[2]);
    case (bus.fault_mask)
      3'b000: begin y_vote = maj;   split_vote = 1'b0; end
      3'b001: begin y_vote = bus.b; split_vote = d_bc; end
      3'b010: begin y_vote = bus.a; split_vote = d_ac; end
      3'b100: begin y_vote = bus.a; split_vote = d_ab; end
      3'b011: begin y_vote = bus.c; split_vote = 1'b0; end
      3'b101: begin y_vote = bus.b; split_vote = 1'b0; end
      3'b110: begin y_vote = bus.a; split_vote = 1'b0; end
      default: begin y_vote = {WIDTH{1'b0}}; split_vote = 1'b0; end
    endcase
  end

  // Streak counters and mask; only tracked while nothing is masked, since two
  // survivors cannot tell which of them is wrong
  always_comb begin
    mcnt_nxt = mcnt;
    mask_nxt = bus.fault_mask;
    for (int i = 0; i < 3; i++) begin
      mism[i] = |(ch[i] ^ maj);
    end
    if (bus.in_valid && (bus.fault_mask == 3'b000)) begin
      for (int i = 0; i < 3; i++) begin
        if (mism[i]) begin
          if ((mcnt[i] + MCNT_ONE) == THRESH_V) begin
            mask_nxt[i] = 1'b1;
            mcnt_nxt[i] = MCNT_ZERO;
          end else begin
            mcnt_nxt[i] = mcnt[i] + MCNT_ONE;
          end
        end else begin
          mcnt_nxt[i] = MCNT_ZERO;
        end
      end
    end else begin
      mcnt_nxt = mcnt;
      mask_nxt = bus.fault_mask;
    end
  end

  // Output, status and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.y          <= {WIDTH{1'b0}};
      bus.disagree   <= 1'b0;
      bus.split      <= 1'b0;
      bus.fault_mask <= 3'b000;
      bus.all_failed <= 1'b0;
      bus.event_cnt  <= {CNT_W{1'b0}};
      mcnt           <= {3{MCNT_ZERO}};
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y        <= y_vote;
        bus.disagree <= dis_vote;
        bus.split    <= split_vote;
        if (dis_vote && (bus.event_cnt != CNT_MAX)) begin
          bus.event_cnt <= bus.event_cnt + CNT_ONE;
        end
      end
      // Clear wins over any streak/mask update from the same sample
      if (bus.clr_fault) begin
        bus.fault_mask <= 3'b000;
        bus.all_failed <= 1'b0;
        mcnt           <= {3{MCNT_ZERO}};
      end else begin
        bus.fault_mask <= mask_nxt;
        bus.all_failed <= (mask_nxt == 3'b111);
        mcnt           <= mcnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Testbench for tmr_vote_monitor: table of stimulus/expected records played
// through a scoreboard queue, plus a saturation run on a narrow-counter copy.
module tb_tmr_vote_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tmr_vote_monitor_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  tmr_vote_monitor_if #(.WIDTH(8), .CNT_W(4))  bus1 ();

  tmr_vote_monitor #(.WIDTH(8), .THRESH(4), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  tmr_vote_monitor #(.WIDTH(8), .THRESH(4), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        rst;
    logic        iv;
    logic        clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        ov;
    logic [7:0]  y;
    logic        dis;
    logic        sp;
    logic [2:0]  mask;
    logic        af;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [40];
  int   nv;
  vec_t sb [$];
  int   sat_q [$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic clr,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic ov, input logic [7:0] y, input logic dis, input logic sp,
                     input logic [2:0] mask, input logic af, input logic [15:0] cnt);
    vt[nv].id = nv;   vt[nv].rst = r;  vt[nv].iv = iv;   vt[nv].clr = clr;
    vt[nv].a = a;     vt[nv].b = b;    vt[nv].c = c;
    vt[nv].ov = ov;   vt[nv].y = y;    vt[nv].dis = dis; vt[nv].sp = sp;
    vt[nv].mask = mask; vt[nv].af = af; vt[nv].cnt = cnt;
    nv++;
  endtask

  task automatic compare_out(input vec_t e);
    chk("out_valid",  e.id, 32'(bus0.out_valid),  32'(e.ov));
    chk("y",          e.id, 32'(bus0.y),          32'(e.y));
    chk("disagree",   e.id, 32'(bus0.disagree),   32'(e.dis));
    chk("split",      e.id, 32'(bus0.split),      32'(e.sp));
    chk("fault_mask", e.id, 32'(bus0.fault_mask), 32'(e.mask));
    chk("all_failed", e.id, 32'(bus0.all_failed), 32'(e.af));
    chk("event_cnt",  e.id, 32'(bus0.event_cnt),  32'(e.cnt));
  endtask

  initial begin
    vec_t e;
    int   ecnt;
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    nv = 0;
    bus0.in_valid = 1'b0; bus0.clr_fault = 1'b0;
    bus0.a = 8'h00; bus0.b = 8'h00; bus0.c = 8'h00;
    bus1.in_valid = 1'b0; bus1.clr_fault = 1'b0;
    bus1.a = 8'h00; bus1.b = 8'h00; bus1.c = 8'h00;

    //  rst   iv    clr   a      b      c      ov    y      dis   sp    mask    af    cnt
    add(1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0);  // agree
    add(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFE, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 3'b000, 1'b0, 16'd1);  // 1-bit fix
    add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 16'd1);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 3'b000, 1'b0, 16'd2);  // b wrong x4
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 3'b000, 1'b0, 16'd3);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 3'b000, 1'b0, 16'd4);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 3'b010, 1'b0, 16'd5);
    add(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 3'b010, 1'b0, 16'd5);  // b ignored
    add(1'b0, 1'b1, 1'b0, 8'h0F, 8'hAA, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b1, 3'b010, 1'b0, 16'd6);  // split
    add(1'b0, 1'b0, 1'b0, 8'h33, 8'h44, 8'h55, 1'b0, 8'h0F, 1'b1, 1'b1, 3'b010, 1'b0, 16'd6);  // gap holds
    add(1'b0, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 3'b000, 1'b0, 16'd6);  // clr + sample
    add(1'b0, 1'b1, 1'b0, 8'hF0, 8'hF0, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b0, 3'b000, 1'b0, 16'd7);  // full vote again
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd8);  // b wrong x3
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd9);
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd10);
    add(1'b0, 1'b1, 1'b0, 8'h77, 8'h77, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0, 3'b000, 1'b0, 16'd10); // streak broken
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd11);
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd12);
    add(1'b0, 1'b1, 1'b0, 8'h10, 8'hEF, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd13);
    add(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h10, 1'b1, 1'b0, 3'b000, 1'b0, 16'd13); // clr streaks
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd14); // all differ x4
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd15);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd16);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0, 3'b111, 1'b1, 16'd17);
    add(1'b0, 1'b1, 1'b0, 8'h55, 8'h66, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 3'b111, 1'b1, 16'd17); // all masked
    add(1'b1, 1'b1, 1'b0, 8'h12, 8'h12, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0);  // reset mid-stream
    add(1'b0, 1'b1, 1'b0, 8'h9C, 8'h9C, 8'h9C, 1'b1, 8'h9C, 1'b0, 1'b0, 3'b000, 1'b0, 16'd0);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd1);  // a,b wrong x4
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd2);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0, 16'd3);
    add(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'b011, 1'b0, 16'd4);
    add(1'b0, 1'b1, 1'b0, 8'hAA, 8'hBB, 8'h5C, 1'b1, 8'h5C, 1'b0, 1'b0, 3'b011, 1'b0, 16'd4);  // only c left
    add(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5C, 1'b0, 1'b0, 3'b011, 1'b0, 16'd4);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid",  -1, 32'(bus0.out_valid),  32'd0);
    chk("rst_y",          -1, 32'(bus0.y),          32'd0);
    chk("rst_disagree",   -1, 32'(bus0.disagree),   32'd0);
    chk("rst_split",      -1, 32'(bus0.split),      32'd0);
    chk("rst_fault_mask", -1, 32'(bus0.fault_mask), 32'd0);
    chk("rst_all_failed", -1, 32'(bus0.all_failed), 32'd0);
    chk("rst_event_cnt",  -1, 32'(bus0.event_cnt),  32'd0);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare_out(e);
      end
      rst = vt[i].rst;
      bus0.in_valid  = vt[i].iv;
      bus0.clr_fault = vt[i].clr;
      bus0.a = vt[i].a;
      bus0.b = vt[i].b;
      bus0.c = vt[i].c;
      sb.push_back(vt[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare_out(e);
    end
    rst = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.clr_fault = 1'b0;

    // Saturation on the 4-bit counter copy: rotate the faulty channel so no
    // streak ever builds and every sample disagrees
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sat_q.size() > 0) begin
        ecnt = sat_q.pop_front();
        chk("sat_event_cnt", i - 1, 32'(bus1.event_cnt), 32'(ecnt));
        chk("sat_disagree",  i - 1, 32'(bus1.disagree),  32'd1);
      end
      bus1.in_valid = 1'b1;
      bus1.a = (i % 3 == 0) ? 8'hFF : 8'h00;
      bus1.b = (i % 3 == 1) ? 8'hFF : 8'h00;
      bus1.c = (i % 3 == 2) ? 8'hFF : 8'h00;
      sat_q.push_back((i + 1 > 15) ? 15 : i + 1);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    if (sat_q.size() > 0) begin
      ecnt = sat_q.pop_front();
      chk("sat_event_cnt_final", 19, 32'(bus1.event_cnt), 32'(ecnt));
      chk("sat_fault_mask",      19, 32'(bus1.fault_mask), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
